mem_out_queue: RTL and testbench

- Parametrised successor to the memory output manager: a circular write queue between the CPU store path and the memory/peripheral bus.
- Accepts address/data pairs and drains them in order to the bus under a Trans/PReady handshake.
- Beyond the original, adds:
  - configurable width and depth;
  - Full and Count status;
  - write coalescing into the youngest entry;
  - a read-forwarding lookup port, so loads see pending stores;
  - a synchronous flush and a sticky overflow flag.

---
 rtl/panzer_pkg.sv | 19 +
 rtl/mem_out_queue_cam.sv | 36 +++
 rtl/mem_out_queue.sv | 122 ++++++++++++
 tb/tb_mem_out_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/panzer_pkg.sv
// Shared definitions for the memory output queue: default widths, the
// queue entry layout and the pointer-width helper.
package panzer_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 16;

   // One pending store at the default widths.
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } entry_t;

   // Pointer width for a ring of 'depth' slots; never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mem_out_queue_cam.sv
// Youngest-match search over the valid window of the ring, oldest slot
// (head) first so that later matches overwrite earlier ones.
module mem_out_queue_cam
   import panzer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   localparam int PTR_W = ptr_w(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
   input  logic [DEPTH-1:0][DATA_W-1:0] datas,
   input  logic [PTR_W-1:0]             head,
   input  logic [CNT_W-1:0]             count,
   input  logic [ADDR_W-1:0]            probe,
   output logic                         hit,
   output logic [DATA_W-1:0]            data
);

   // Walk head .. head+count-1; the last match seen is the youngest.
   always_comb begin
      logic [PTR_W-1:0] slot;
      hit  = 1'b0;
      data = '0;
      slot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && (addrs[slot] == probe)) begin
            hit  = 1'b1;
            data = datas[slot];
         end
      end
   end

endmodule

// File: rtl/mem_out_queue.sv
// Circular write queue between the CPU store path and the bus, with
// coalescing into the youngest entry, read forwarding, flush and a sticky
// overflow flag.
//
// Bus handshake: Trans is the valid, PReady the ready. The head entry is
// transferred on a rising edge where Trans && PReady; while Trans && !PReady
// AdressOut/DataOut hold steady. Trans never depends on PReady.
module mem_out_queue
   import panzer_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DEPTH    = 4,
   parameter int COALESCE = 1,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Flush,
   input  logic              Enqueue,
   input  logic [ADDR_W-1:0] AdressIn,
   input  logic [DATA_W-1:0] DataIn,
   input  logic              PReady,
   output logic              Trans,
   output logic [ADDR_W-1:0] AdressOut,
   output logic [DATA_W-1:0] DataOut,
   output logic              Empty,
   output logic              Full,
   output logic              Busy,
   output logic [CNT_W-1:0]  Count,
   output logic              Overflow,
   input  logic [ADDR_W-1:0] LookupAdress,
   output logic              LookupHit,
   output logic [DATA_W-1:0] LookupData
);

   localparam int PTR_W = ptr_w(DEPTH);

   logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
   logic [DEPTH-1:0][DATA_W-1:0] mem_data;
   logic [PTR_W-1:0]             head, tail, tail_m1;
   logic [CNT_W-1:0]             count;
   logic                         overflow;
   logic                         empty, full;
   logic                         do_push, do_pop, do_coalesce, do_drop;

   // Action decode on the pre-edge state; a pop never frees room for a
   // same-cycle push, and the head entry (count < 2) is never merged into.
   always_comb begin
      empty       = (count == '0);
      full        = (count == CNT_W'(DEPTH));
      tail_m1     = tail - PTR_W'(1);
      do_pop      = !empty && PReady;
      do_coalesce = (COALESCE != 0) && Enqueue && (count >= CNT_W'(2)) &&
                    (AdressIn == mem_addr[tail_m1]);
      do_push     = Enqueue && !full && !do_coalesce;
      do_drop     = Enqueue && full && !do_coalesce;
   end

   // Pointer, count and overflow state; Flush overrides every other action.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (Flush) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) tail <= tail + PTR_W'(1);
         if (do_pop)  head <= head + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (do_drop) overflow <= 1'b1;
      end
   end

   // Entry storage; contents outside the valid window are never observed.
   always_ff @(posedge Clk) begin
      if (!Flush) begin
         if (do_push) begin
            mem_addr[tail] <= AdressIn;
            mem_data[tail] <= DataIn;
         end else if (do_coalesce) begin
            mem_data[tail_m1] <= DataIn;
         end
      end
   end

   // Head presentation and status, gated so stale storage never leaks.
   always_comb begin
      Trans     = !empty;
      AdressOut = empty ? '0 : mem_addr[head];
      DataOut   = empty ? '0 : mem_data[head];
      Empty     = empty;
      Full      = full;
      Busy      = full || Flush;
      Count     = count;
      Overflow  = overflow;
   end

   mem_out_queue_cam #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cam (
      .addrs (mem_addr),
      .datas (mem_data),
      .head  (head),
      .count (count),
      .probe (LookupAdress),
      .hit   (LookupHit),
      .data  (LookupData)
   );

endmodule

// File: tb/tb_mem_out_queue.sv
// Bench for mem_out_queue: directed scenarios plus random traffic, checked
// against a queue-of-pending-stores model; bus transfers are scored by an
// independent monitor.
module tb_mem_out_queue;
   import panzer_pkg::*;

   localparam int DEPTH = 4;
   localparam int COAL  = 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic        Clk, Rst, Flush, Enqueue, PReady;
   logic [15:0] AdressIn, DataIn, LookupAdress;
   logic        Trans, Empty, Full, Busy, Overflow, LookupHit;
   logic [15:0] AdressOut, DataOut, LookupData;
   logic [CW-1:0] Count;
   logic        nc_trans, nc_empty, nc_full, nc_busy, nc_overflow, nc_hit;
   logic [15:0] nc_aout, nc_dout, nc_ldata;
   logic [CW-1:0] nc_count;

   int     checks = 0;
   int     errors = 0;
   entry_t exp_q[$];
   logic   ovf_m;

   mem_out_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .COALESCE(COAL)) dut (
      .Clk(Clk), .Rst(Rst), .Flush(Flush), .Enqueue(Enqueue),
      .AdressIn(AdressIn), .DataIn(DataIn), .PReady(PReady),
      .Trans(Trans), .AdressOut(AdressOut), .DataOut(DataOut),
      .Empty(Empty), .Full(Full), .Busy(Busy), .Count(Count),
      .Overflow(Overflow), .LookupAdress(LookupAdress),
      .LookupHit(LookupHit), .LookupData(LookupData)
   );

   mem_out_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .COALESCE(0)) dut_nc (
      .Clk(Clk), .Rst(Rst), .Flush(Flush), .Enqueue(Enqueue),
      .AdressIn(AdressIn), .DataIn(DataIn), .PReady(PReady),
      .Trans(nc_trans), .AdressOut(nc_aout), .DataOut(nc_dout),
      .Empty(nc_empty), .Full(nc_full), .Busy(nc_busy), .Count(nc_count),
      .Overflow(nc_overflow), .LookupAdress(LookupAdress),
      .LookupHit(nc_hit), .LookupData(nc_ldata)
   );

   // Clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Youngest pending store to 'la', straight from the model queue.
   task automatic model_lookup(input logic [15:0] la, output logic hit, output logic [15:0] d);
      hit = 1'b0;
      d   = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].addr == la) begin
            hit = 1'b1;
            d   = exp_q[i].data;
            break;
         end
      end
   endtask

   task automatic check_status();
      chk("count", 32'(Count), exp_q.size());
      chk("empty", 32'(Empty), 32'(exp_q.size() == 0));
      chk("full", 32'(Full), 32'(exp_q.size() == DEPTH));
      chk("trans", 32'(Trans), 32'(exp_q.size() != 0));
      chk("overflow", 32'(Overflow), 32'(ovf_m));
   endtask

   task automatic check_comb();
      logic        hit;
      logic [15:0] d;
      model_lookup(LookupAdress, hit, d);
      chk("lookup_hit", 32'(LookupHit), 32'(hit));
      chk("lookup_data", 32'(LookupData), 32'(d));
      chk("busy", 32'(Busy), 32'((exp_q.size() == DEPTH) || Flush));
      chk("head_addr", 32'(AdressOut), (exp_q.size() != 0) ? 32'(exp_q[0].addr) : 32'h0);
      chk("head_data", 32'(DataOut), (exp_q.size() != 0) ? 32'(exp_q[0].data) : 32'h0);
   endtask

   // Apply this cycle's request to the model; pops are left to the monitor.
   task automatic model_step(input logic en, input logic [15:0] a, input logic [15:0] d,
                             input logic fl);
      entry_t e;
      if (fl) begin
         exp_q.delete();
         ovf_m = 1'b0;
      end else if (en) begin
         if (COAL != 0 && exp_q.size() >= 2 && exp_q[exp_q.size()-1].addr == a) begin
            e      = exp_q[exp_q.size()-1];
            e.data = d;
            exp_q[exp_q.size()-1] = e;
         end else if (exp_q.size() == DEPTH) begin
            ovf_m = 1'b1;
         end else begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
         end
      end
   endtask

   // Driver: one clock cycle of stimulus with pre-edge checks.
   task automatic cycle(input logic en, input logic [15:0] a, input logic [15:0] d,
                        input logic pr, input logic fl, input logic [15:0] la);
      @(posedge Clk);
      #1;
      check_status();
      Enqueue = en; AdressIn = a; DataIn = d; PReady = pr; Flush = fl; LookupAdress = la;
      #1;
      check_comb();
      model_step(en, a, d, fl);
   endtask

   task automatic check_reset();
      chk("rst_trans", 32'(Trans), 0);
      chk("rst_empty", 32'(Empty), 1);
      chk("rst_full", 32'(Full), 0);
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_count", 32'(Count), 0);
      chk("rst_overflow", 32'(Overflow), 0);
      chk("rst_addr", 32'(AdressOut), 0);
      chk("rst_data", 32'(DataOut), 0);
      chk("rst_hit", 32'(LookupHit), 0);
      chk("rst_ldata", 32'(LookupData), 0);
   endtask

   // Monitor: score every bus transfer against the oldest pending store.
   always @(negedge Clk) begin
      if (Rst && Trans && PReady && !Flush) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_pop: transfer of %h/%h with nothing pending", AdressOut, DataOut);
         end else begin
            chk("bus_addr", 32'(AdressOut), 32'(exp_q[0].addr));
            chk("bus_data", 32'(DataOut), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      Rst = 1'b0; Flush = 1'b0; Enqueue = 1'b0; PReady = 1'b0;
      AdressIn = '0; DataIn = '0; LookupAdress = 16'h0010;
      ovf_m = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check_reset();
      @(negedge Clk);
      #1;
      Rst = 1'b1;

      // 1: single store, held by PReady=0, then accepted
      cycle(1, 16'h0010, 16'hAAAA, 0, 0, 16'h0010);
      repeat (3) cycle(0, 0, 0, 0, 0, 16'h0010);
      chk("t1_hold_addr", 32'(AdressOut), 32'h0010);
      chk("t1_hold_data", 32'(DataOut), 32'hAAAA);
      cycle(0, 0, 0, 1, 0, 16'h0010);
      cycle(0, 0, 0, 0, 0, 16'h0010);
      chk("t1_empty", 32'(Empty), 1);

      // 2: fill, drop one, drain in order
      for (int i = 1; i <= 4; i++) cycle(1, 16'(i), 16'(16'h0100 + i), 0, 0, 16'h0003);
      cycle(1, 16'h0005, 16'h0105, 0, 0, 16'h0003);
      chk("t2_busy", 32'(Busy), 1);
      cycle(0, 0, 0, 0, 0, 16'h0005);
      chk("t2_overflow", 32'(Overflow), 1);
      chk("t2_count", 32'(Count), 4);
      repeat (5) cycle(0, 0, 0, 1, 0, 16'h0002);

      // 3: coalesce into youngest entry; the non-merging instance keeps three
      cycle(0, 0, 0, 0, 1, 16'h0000);
      cycle(1, 16'h0020, 16'h1111, 0, 0, 16'h0030);
      cycle(1, 16'h0030, 16'h2222, 0, 0, 16'h0030);
      cycle(1, 16'h0030, 16'h3333, 0, 0, 16'h0030);
      cycle(0, 0, 0, 0, 0, 16'h0030);
      chk("t3_count", 32'(Count), 2);
      chk("t3_nc_count", 32'(nc_count), 3);
      chk("t3_fwd", 32'(LookupData), 32'h3333);
      repeat (3) cycle(0, 0, 0, 1, 0, 16'h0030);

      // 4: forwarding picks the youngest match
      cycle(1, 16'h0040, 16'h0005, 0, 0, 16'h0040);
      cycle(1, 16'h0044, 16'h0006, 0, 0, 16'h0040);
      cycle(1, 16'h0040, 16'h0007, 0, 0, 16'h0040);
      cycle(0, 0, 0, 0, 0, 16'h0040);
      chk("t4_hit", 32'(LookupHit), 1);
      chk("t4_data", 32'(LookupData), 32'h0007);
      cycle(0, 0, 0, 0, 0, 16'h0048);
      chk("t4_miss_hit", 32'(LookupHit), 0);
      chk("t4_miss_data", 32'(LookupData), 0);

      // 5: simultaneous push and pop at count 3 across pointer wrap
      for (int i = 0; i < 12; i++)
         cycle(1, 16'(16'h0100 + i), 16'($urandom), 1, 0, 16'(16'h0100 + i));
      cycle(0, 0, 0, 0, 0, 16'h0000);
      chk("t5_count", 32'(Count), 3);
      repeat (4) cycle(0, 0, 0, 1, 0, 16'h0000);

      // 6: flush beats push/pop and clears overflow; async reset mid-transfer
      for (int i = 0; i < 5; i++) cycle(1, 16'(16'h0200 + i), 16'(i), 0, 0, 16'h0000);
      cycle(1, 16'h0300, 16'h0001, 1, 1, 16'h0000);
      cycle(0, 0, 0, 0, 0, 16'h0300);
      chk("t6_empty", 32'(Empty), 1);
      chk("t6_overflow", 32'(Overflow), 0);
      cycle(1, 16'h0400, 16'h0400, 0, 0, 16'h0400);
      cycle(1, 16'h0401, 16'h0401, 0, 0, 16'h0400);
      @(posedge Clk);
      #3;
      Rst = 1'b0;
      Enqueue = 1'b0; PReady = 1'b0; Flush = 1'b0;
      #1;
      check_reset();
      exp_q.delete();
      ovf_m = 1'b0;
      @(negedge Clk);
      #2;
      Rst = 1'b1;

      // Random traffic on a small address set to exercise merge and forwarding
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 9) < 6), 16'($urandom_range(0, 7)), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0),
               16'($urandom_range(0, 7)));
      repeat (DEPTH + 2) cycle(0, 0, 0, 1, 0, 16'h0000);
      chk("final_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
